branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Consumer side of the EX-stage branch comparator.
- Drives BrUn from the EX instruction's funct3 and takes BrEq/BrLt back.
- Resolves conditional branches and jumps, and checks the fetch-stage prediction from a 2-bit bimodal history table.
- On a wrong path, runs a fixed two-cycle redirect/flush sequence toward IF/ID/EX. Also keeps branch and mispredict performance counters.

Parameters:
- BHT_DEPTH, 64, number of 2-bit history entries (power of 2); IDX_W = log2(BHT_DEPTH).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_pc  in  32  PC of the instruction being fetched
- if_pred_taken  out  1  prediction for if_pc (fetch predecodes the B-type target)
- ex_valid  in  1  EX holds a live instruction
- ex_stall  in  1  EX is frozen this cycle
- ex_branch  in  1  EX instruction is a conditional branch
- ex_jump  in  1  EX instruction is JAL/JALR
- ex_funct3  in  3  funct3 of the EX instruction
- ex_pc  in  32  PC of the EX instruction
- ex_target  in  32  computed branch/jump target
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- BrEq  in  1  comparator equal
- BrLt  in  1  comparator less-than
- BrUn  out  1  unsigned compare select to the comparator
- pc_sel  out  1  select pc_redirect as next PC
- pc_redirect  out  32  redirect address
- flush_if_id  out  1  squash the IF/ID register
- flush_id_ex  out  1  squash the ID/EX register
- branch_cnt  out  CNT_W  resolved conditional branches
- mispredict_cnt  out  CNT_W  mispredicted conditional branches

Behaviour:
- BrUn = ex_funct3[1], combinational, independent of state.
- Taken decode (conditional branches):
  - 000 → BrEq; 001 → !BrEq
  - 100 and 110 → BrLt; 101 and 111 → !BrLt
  - 010 and 011 are illegal: not taken, no BHT update, not counted.
- resolve = ex_valid & !ex_stall & state==IDLE.
- Jumps:
  - ex_jump has priority over ex_branch.
  - A resolved jump always redirects to ex_target.
  - No BHT update; not counted in either counter.
- Conditional-branch mispredict = resolve & ex_branch & (taken != ex_pred_taken).
  - Redirect address = ex_target if taken, else ex_pc+4 (32-bit wrap).
- FSM states IDLE and REDIRECT.
  - IDLE: on a mispredict or resolved jump in cycle N:
    - assert flush_if_id and flush_id_ex combinationally in N;
    - register the redirect address;
    - go to REDIRECT.
  - REDIRECT (cycle N+1), always exactly one cycle:
    - pc_sel=1, pc_redirect=registered address, flush_if_id=1, flush_id_ex=1;
    - all EX inputs are ignored (squashed slot), ex_stall included;
    - return to IDLE. Fetch from the target occurs in N+2, giving a 3-cycle penalty.
  - IDLE outputs otherwise: pc_sel=0, flush_*=0, pc_redirect holds its last value.
- BHT:
  - BHT_DEPTH 2-bit saturating counters, index = pc[IDX_W+1:2].
  - if_pred_taken = bht[if_pc index][1], combinational read.
  - On resolve & ex_branch & legal funct3: increment (saturate at 11) if taken, else decrement (saturate at 00), indexed by ex_pc. The write takes effect next cycle.
  - Same-index read and write in one cycle: the read returns the old value (no bypass).
- Counters:
  - branch_cnt increments on each legal resolved conditional branch.
  - mispredict_cnt increments on each mispredict.
  - Both saturate at all-ones.
- Reset (also mid-REDIRECT):
  - state=IDLE; pc_sel=0; flush_*=0; pc_redirect=0;
  - all BHT entries=01 (weakly not-taken); both counters=0; if_pred_taken reads 0.

Decomposition:
- Shared package holds:
  - funct3 constants F3_BEQ/BNE/BLT/BGE/BLTU/BGEU;
  - the state enum IDLE/REDIRECT;
  - BHT reset value 2'b01.
- One sub-module, bht_2bit: counter array with combinational read port, saturating update port and synchronous reset. The top module holds the decode, FSM and counters.

Test Plan:
- After reset, BEQ with ex_pc=0x100, ex_target=0x140, BrEq=1, ex_pred_taken=0 → cycle N flush_if_id=flush_id_ex=1; N+1 pc_sel=1, pc_redirect=0x140; mispredict_cnt=1, branch_cnt=1; bht[0x100 index]=10.
- BGEU, BrLt=1, pred=1, ex_pc=0x200 → BrUn=1, not taken; redirect to 0x204 at N+1; entry decrements 01→00.
- Four taken BNE at the same PC, pred matching the BHT each time → entry saturates at 11; later lookups give if_pred_taken=1; no flush on predicted-correct branches.
- Mispredicting branch with ex_stall=1 for 3 cycles → no flush and no counter/BHT change until the stall drops, then the normal 2-cycle sequence.
- JAL in EX with ex_branch also high → redirect to ex_target; counters and BHT unchanged. A branch in the REDIRECT cycle is ignored.
- rst asserted during REDIRECT → next cycle pc_sel=0, flushes=0, counters=0, BHT back to 01.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the EX-stage branch resolution block.
//   - funct3 encodings of the conditional branches
//   - redirect FSM state enum
//   - BHT counter reset value and helper functions for the taken
//     decode and the 2-bit saturating update
package branch_resolve_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] BHT_RST = 2'b01;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  // 010 and 011 are not branch encodings.
  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3[2:1] != 2'b01);
  endfunction

  // Signed/unsigned selection is done by the comparator via BrUn, so the
  // signed and unsigned forms share the same BrLt decode here.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       eq,
                                        input logic       lt);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:            t = eq;
      F3_BNE:            t = !eq;
      F3_BLT,  F3_BLTU:  t = lt;
      F3_BGE,  F3_BGEU:  t = !lt;
      default:           t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                          input logic       taken);
    logic [1:0] n;
    n = ctr;
    if (taken && ctr != 2'b11)
      n = ctr + 2'b01;
    else if (!taken && ctr != 2'b00)
      n = ctr - 2'b01;
    return n;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Pipeline-side signal bundle of branch_resolve_ctrl.
//   slave  : view used by branch_resolve_ctrl (fetch/EX/comparator inputs,
//            prediction/BrUn/redirect/flush/counter outputs)
//   master : view used by the surrounding pipeline (or a testbench)
interface branch_resolve_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      if_pc;
  logic             if_pred_taken;
  logic             ex_valid;
  logic             ex_stall;
  logic             ex_branch;
  logic             ex_jump;
  logic [2:0]       ex_funct3;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_target;
  logic             ex_pred_taken;
  logic             BrEq;
  logic             BrLt;
  logic             BrUn;
  logic             pc_sel;
  logic [31:0]      pc_redirect;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport slave (
    input  if_pc, ex_valid, ex_stall, ex_branch, ex_jump, ex_funct3,
           ex_pc, ex_target, ex_pred_taken, BrEq, BrLt,
    output if_pred_taken, BrUn, pc_sel, pc_redirect, flush_if_id,
           flush_id_ex, branch_cnt, mispredict_cnt
  );

  modport master (
    output if_pc, ex_valid, ex_stall, ex_branch, ex_jump, ex_funct3,
           ex_pc, ex_target, ex_pred_taken, BrEq, BrLt,
    input  if_pred_taken, BrUn, pc_sel, pc_redirect, flush_if_id,
           flush_id_ex, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_ctrl_bht_2bit.sv
// bht_2bit: array of 2-bit saturating branch history counters.
//   clk, rst     : clock, synchronous active-high reset (all entries -> 01)
//   rd_idx_i     : combinational read index
//   rd_ctr_o     : counter at rd_idx_i (pre-update value, no write bypass)
//   wr_en_i      : apply a saturating update this cycle
//   wr_idx_i     : index to update
//   wr_taken_i   : 1 = increment toward 11, 0 = decrement toward 00
module bht_2bit
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] wr_ctr_d;

  assign rd_ctr_o = ctr_q[rd_idx_i];
  assign wr_ctr_d = ctr_next(ctr_q[wr_idx_i], wr_taken_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        ctr_q[i] <= BHT_RST;
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= wr_ctr_d;
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: resolves EX-stage branches/jumps, checks the fetch
// prediction held in a 2-bit bimodal table, and runs a two-cycle
// redirect/flush sequence on a wrong path.
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_resolve_ctrl_if.slave (fetch PC/prediction, EX
//              instruction info, comparator BrEq/BrLt/BrUn, pc_sel,
//              pc_redirect, flush_if_id, flush_id_ex, branch_cnt,
//              mispredict_cnt)
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  state_e           state_q, state_d;
  logic [31:0]      redir_q, redir_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic        resolve;
  logic        legal;
  logic        taken;
  logic        jump_res;
  logic        br_res;
  logic        mispredict;
  logic        redirect_go;
  logic [31:0] redir_addr;
  logic [1:0]  rd_ctr;

  assign bus.BrUn = bus.ex_funct3[1];

  // Resolve only from IDLE: the REDIRECT cycle's EX slot is being squashed.
  assign resolve  = bus.ex_valid && !bus.ex_stall && (state_q == IDLE);
  assign legal    = f3_legal(bus.ex_funct3);
  assign taken    = branch_taken(bus.ex_funct3, bus.BrEq, bus.BrLt);
  assign jump_res = resolve && bus.ex_jump;
  // Jumps take priority, so a jump with ex_branch set is never a branch.
  assign br_res     = resolve && bus.ex_branch && !bus.ex_jump && legal;
  assign mispredict = resolve && bus.ex_branch && !bus.ex_jump &&
                      (taken != bus.ex_pred_taken);
  assign redirect_go = jump_res || mispredict;
  assign redir_addr  = (jump_res || taken) ? bus.ex_target
                                           : (bus.ex_pc + 32'd4);

  bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (bus.if_pc[IDX_W+1:2]),
    .rd_ctr_o   (rd_ctr),
    .wr_en_i    (br_res),
    .wr_idx_i   (bus.ex_pc[IDX_W+1:2]),
    .wr_taken_i (taken)
  );

  assign bus.if_pred_taken = rd_ctr[1];

  always_comb begin
    state_d         = state_q;
    redir_d         = redir_q;
    bus.pc_sel      = 1'b0;
    bus.flush_if_id = 1'b0;
    bus.flush_id_ex = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_go) begin
          bus.flush_if_id = 1'b1;
          bus.flush_id_ex = 1'b1;
          redir_d         = redir_addr;
          state_d         = REDIRECT;
        end
      end
      REDIRECT: begin
        bus.pc_sel      = 1'b1;
        bus.flush_if_id = 1'b1;
        bus.flush_id_ex = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (br_res && (br_cnt_q != '1))
      br_cnt_d = br_cnt_q + 1'b1;
    // Illegal encodings are never counted, even if they redirect.
    if (mispredict && legal && (mp_cnt_q != '1))
      mp_cnt_d = mp_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      redir_q  <= '0;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      redir_q  <= redir_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign bus.pc_redirect    = redir_q;
  assign bus.branch_cnt     = br_cnt_q;
  assign bus.mispredict_cnt = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  branch_resolve_ctrl_if #(.CNT_W(32)) bus ();

  branch_resolve_ctrl #(
    .BHT_DEPTH (64),
    .CNT_W     (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    bus.ex_valid      = 1'b0;
    bus.ex_stall      = 1'b0;
    bus.ex_branch     = 1'b0;
    bus.ex_jump       = 1'b0;
    bus.ex_funct3     = 3'b000;
    bus.ex_pc         = 32'h0;
    bus.ex_target     = 32'h0;
    bus.ex_pred_taken = 1'b0;
    bus.BrEq          = 1'b0;
    bus.BrLt          = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_ex();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_br(input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic eq,
                          input logic lt, input logic pred);
    bus.ex_valid      = 1'b1;
    bus.ex_stall      = 1'b0;
    bus.ex_branch     = 1'b1;
    bus.ex_jump       = 1'b0;
    bus.ex_funct3     = f3;
    bus.ex_pc         = pc;
    bus.ex_target     = tgt;
    bus.BrEq          = eq;
    bus.BrLt          = lt;
    bus.ex_pred_taken = pred;
  endtask

  logic [1:0] m;
  logic       mp;

  initial begin
    bus.if_pc = 32'h100;
    do_reset();

    // Reset state
    check_eq("rst_pc_sel", 32'(bus.pc_sel), 32'h0);
    check_eq("rst_flush_if_id", 32'(bus.flush_if_id), 32'h0);
    check_eq("rst_flush_id_ex", 32'(bus.flush_id_ex), 32'h0);
    check_eq("rst_pc_redirect", bus.pc_redirect, 32'h0);
    check_eq("rst_branch_cnt", bus.branch_cnt, 32'h0);
    check_eq("rst_mp_cnt", bus.mispredict_cnt, 32'h0);
    check_eq("rst_if_pred", 32'(bus.if_pred_taken), 32'h0);

    // BEQ taken, predicted not taken
    drive_br(3'b000, 32'h100, 32'h140, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("beq_BrUn", 32'(bus.BrUn), 32'h0);
    check_eq("beq_N_flush_if_id", 32'(bus.flush_if_id), 32'h1);
    check_eq("beq_N_flush_id_ex", 32'(bus.flush_id_ex), 32'h1);
    check_eq("beq_N_pc_sel", 32'(bus.pc_sel), 32'h0);
    tick();
    idle_ex();
    #1;
    check_eq("beq_N1_pc_sel", 32'(bus.pc_sel), 32'h1);
    check_eq("beq_N1_pc_redirect", bus.pc_redirect, 32'h140);
    check_eq("beq_N1_flush_if_id", 32'(bus.flush_if_id), 32'h1);
    check_eq("beq_N1_flush_id_ex", 32'(bus.flush_id_ex), 32'h1);
    check_eq("beq_mp_cnt", bus.mispredict_cnt, 32'h1);
    check_eq("beq_br_cnt", bus.branch_cnt, 32'h1);
    check_eq("beq_bht", 32'(dut.u_bht.ctr_q[0]), 32'h2);
    tick();
    check_eq("beq_N2_pc_sel", 32'(bus.pc_sel), 32'h0);
    check_eq("beq_N2_flush", 32'(bus.flush_if_id), 32'h0);
    check_eq("beq_N2_redirect_hold", bus.pc_redirect, 32'h140);

    // BGEU not taken, predicted taken
    do_reset();
    drive_br(3'b111, 32'h200, 32'h280, 1'b0, 1'b1, 1'b1);
    #1;
    check_eq("bgeu_BrUn", 32'(bus.BrUn), 32'h1);
    check_eq("bgeu_N_flush", 32'(bus.flush_id_ex), 32'h1);
    tick();
    idle_ex();
    #1;
    check_eq("bgeu_N1_pc_sel", 32'(bus.pc_sel), 32'h1);
    check_eq("bgeu_N1_redirect", bus.pc_redirect, 32'h204);
    check_eq("bgeu_bht", 32'(dut.u_bht.ctr_q[0]), 32'h0);
    check_eq("bgeu_mp_cnt", bus.mispredict_cnt, 32'h1);
    tick();

    // Four taken BNE at 0x10C (index 3), prediction follows the table
    do_reset();
    bus.if_pc = 32'h10C;
    m = 2'b01;
    for (int i = 0; i < 4; i++) begin
      drive_br(3'b001, 32'h10C, 32'h150, 1'b0, 1'b0, m[1]);
      #1;
      mp = !m[1];
      check_eq($sformatf("bne%0d_if_pred", i), 32'(bus.if_pred_taken), 32'(m[1]));
      check_eq($sformatf("bne%0d_flush", i), 32'(bus.flush_if_id), 32'(mp));
      tick();
      m = (m == 2'b11) ? 2'b11 : m + 2'b01;
      if (mp) begin
        idle_ex();
        #1;
        check_eq($sformatf("bne%0d_redirect", i), bus.pc_redirect, 32'h150);
        tick();
      end
    end
    idle_ex();
    #1;
    check_eq("bne_bht_sat", 32'(dut.u_bht.ctr_q[3]), 32'h3);
    check_eq("bne_if_pred", 32'(bus.if_pred_taken), 32'h1);
    check_eq("bne_br_cnt", bus.branch_cnt, 32'h4);
    check_eq("bne_mp_cnt", bus.mispredict_cnt, 32'h1);

    // Mispredict held by a 3-cycle stall
    do_reset();
    drive_br(3'b000, 32'h100, 32'h180, 1'b1, 1'b0, 1'b0);
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("stall%0d_flush", i), 32'(bus.flush_if_id), 32'h0);
      tick();
      check_eq($sformatf("stall%0d_pc_sel", i), 32'(bus.pc_sel), 32'h0);
      check_eq($sformatf("stall%0d_br_cnt", i), bus.branch_cnt, 32'h0);
      check_eq($sformatf("stall%0d_bht", i), 32'(dut.u_bht.ctr_q[0]), 32'h1);
    end
    bus.ex_stall = 1'b0;
    #1;
    check_eq("unstall_flush", 32'(bus.flush_if_id), 32'h1);
    tick();
    idle_ex();
    #1;
    check_eq("unstall_pc_sel", 32'(bus.pc_sel), 32'h1);
    check_eq("unstall_redirect", bus.pc_redirect, 32'h180);
    check_eq("unstall_mp_cnt", bus.mispredict_cnt, 32'h1);
    tick();

    // JAL with ex_branch also high; branch in REDIRECT slot ignored
    do_reset();
    drive_br(3'b000, 32'h100, 32'h400, 1'b1, 1'b0, 1'b0);
    bus.ex_jump = 1'b1;
    #1;
    check_eq("jal_flush", 32'(bus.flush_if_id), 32'h1);
    tick();
    drive_br(3'b000, 32'h100, 32'h500, 1'b1, 1'b0, 1'b0);
    bus.ex_stall = 1'b1;
    #1;
    check_eq("jal_N1_pc_sel", 32'(bus.pc_sel), 32'h1);
    check_eq("jal_N1_redirect", bus.pc_redirect, 32'h400);
    check_eq("jal_N1_flush", 32'(bus.flush_id_ex), 32'h1);
    tick();
    idle_ex();
    #1;
    check_eq("jal_N2_pc_sel", 32'(bus.pc_sel), 32'h0);
    check_eq("jal_N2_redirect", bus.pc_redirect, 32'h400);
    check_eq("jal_br_cnt", bus.branch_cnt, 32'h0);
    check_eq("jal_mp_cnt", bus.mispredict_cnt, 32'h0);
    check_eq("jal_bht", 32'(dut.u_bht.ctr_q[0]), 32'h1);

    // Illegal funct3 010, predicted not taken: nothing happens
    drive_br(3'b010, 32'h100, 32'h600, 1'b1, 1'b1, 1'b0);
    #1;
    check_eq("ill_flush", 32'(bus.flush_if_id), 32'h0);
    tick();
    idle_ex();
    #1;
    check_eq("ill_br_cnt", bus.branch_cnt, 32'h0);
    check_eq("ill_bht", 32'(dut.u_bht.ctr_q[0]), 32'h1);

    // Reset asserted during REDIRECT
    bus.if_pc = 32'h100;
    drive_br(3'b000, 32'h100, 32'h140, 1'b1, 1'b0, 1'b0);
    tick();
    idle_ex();
    #1;
    check_eq("pre_rst_pc_sel", 32'(bus.pc_sel), 32'h1);
    check_eq("pre_rst_bht", 32'(dut.u_bht.ctr_q[0]), 32'h2);
    rst = 1'b1;
    tick();
    check_eq("midrst_pc_sel", 32'(bus.pc_sel), 32'h0);
    check_eq("midrst_flush_if_id", 32'(bus.flush_if_id), 32'h0);
    check_eq("midrst_flush_id_ex", 32'(bus.flush_id_ex), 32'h0);
    check_eq("midrst_redirect", bus.pc_redirect, 32'h0);
    check_eq("midrst_br_cnt", bus.branch_cnt, 32'h0);
    check_eq("midrst_mp_cnt", bus.mispredict_cnt, 32'h0);
    check_eq("midrst_bht", 32'(dut.u_bht.ctr_q[0]), 32'h1);
    check_eq("midrst_if_pred", 32'(bus.if_pred_taken), 32'h0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
